// File: rtl/flag_update_ctrl_pkg.sv
// Shared definitions for the status-flag update controller: FSM encoding,
// NZCV bit positions and the "always" condition code.
package flag_update_ctrl_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  typedef logic [3:0] nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL_CODE = 4'b1110;

endpackage

// File: rtl/flag_update_ctrl_merge.sv
// Bitwise NZCV merge: masked bits come from the new data, the rest keep the
// current status-register value.
module flag_merge
  import flag_update_ctrl_pkg::*;
(
  input  nzcv_t i_cur,
  input  nzcv_t i_mask,
  input  nzcv_t i_data,
  output nzcv_t o_flags
);

  assign o_flags = (i_data & i_mask) | (i_cur & ~i_mask);

endmodule

// File: rtl/flag_update_ctrl.sv
// Arbitrates ALU, MSR and multicycle-multiply writes into the NZCV status
// register and holds EXE / stalls conditional ID instructions during a multiply.
module flag_update_ctrl
  import flag_update_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter logic [3:0]  COND_AL = COND_AL_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_s,
  input  logic [3:0] alu_flags,
  input  logic       mul_start,
  input  logic       mul_s,
  input  logic [3:0] mul_flags,
  input  logic       msr_we,
  input  logic [3:0] msr_mask,
  input  logic [3:0] msr_data,
  input  logic [3:0] flags_cur,
  input  logic       id_cond_valid,
  input  logic [3:0] id_cond,
  output logic       sr_we,
  output logic [3:0] sr_flags,
  output logic       exe_hold,
  output logic       id_stall,
  output logic       err
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_sr_we;
  nzcv_t      r_sr_flags;
  logic       r_err;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_sr_we_nxt;
  nzcv_t      w_sr_flags_nxt;
  logic       w_err_nxt;
  nzcv_t      w_msr_merged;

  flag_merge u_flag_merge (
    .i_cur   (flags_cur),
    .i_mask  (msr_mask),
    .i_data  (msr_data),
    .o_flags (w_msr_merged)
  );

  // NOTE: every variable gets a default first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sr_we_nxt    = 1'b0;
    w_sr_flags_nxt = r_sr_flags;
    w_err_nxt      = r_err;

    case (r_state)
      ST_IDLE: begin
        if (msr_we) begin
          w_sr_we_nxt    = 1'b1;
          w_sr_flags_nxt = w_msr_merged;
          if (alu_s) w_err_nxt = 1'b1;
        end else if (alu_s) begin
          w_sr_we_nxt    = 1'b1;
          w_sr_flags_nxt = alu_flags;
        end
        if (mul_start && mul_s) begin
          w_state_nxt = ST_MUL_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end

      ST_MUL_WAIT: begin
        // Held ALU/MSR requests are dropped here; the core re-presents them.
        if (mul_start) w_err_nxt = 1'b1;
        if (r_cnt == 4'd0) begin
          w_sr_we_nxt    = 1'b1;
          w_sr_flags_nxt = mul_flags;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_sr_we    <= 1'b0;
      r_sr_flags <= 4'b0000;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sr_we    <= w_sr_we_nxt;
      r_sr_flags <= w_sr_flags_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign sr_we    = r_sr_we;
  assign sr_flags = r_sr_flags;
  assign err      = r_err;
  assign exe_hold = (r_state == ST_MUL_WAIT);
  assign id_stall = id_cond_valid && (id_cond != COND_AL) && (r_state == ST_MUL_WAIT);

endmodule

// File: tb/tb_flag_update_ctrl.sv
// Scoreboard bench for flag_update_ctrl: expected status-register writes are
// queued with their target cycle when stimulus is driven and matched each cycle.
module tb_flag_update_ctrl;

  localparam int unsigned MUL_LAT = 3;
  localparam logic [3:0]  COND_AL = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_s, mul_start, mul_s, msr_we, id_cond_valid;
  logic [3:0] alu_flags, mul_flags, msr_mask, msr_data, flags_cur, id_cond;
  logic       sr_we, exe_hold, id_stall, err;
  logic [3:0] sr_flags;

  logic [3:0] r_status;
  logic [3:0] m_status;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  flags;
  } exp_t;
  exp_t exp_q[$];

  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  flag_update_ctrl #(.MUL_LAT(MUL_LAT), .COND_AL(COND_AL)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_s         (alu_s),
    .alu_flags     (alu_flags),
    .mul_start     (mul_start),
    .mul_s         (mul_s),
    .mul_flags     (mul_flags),
    .msr_we        (msr_we),
    .msr_mask      (msr_mask),
    .msr_data      (msr_data),
    .flags_cur     (flags_cur),
    .id_cond_valid (id_cond_valid),
    .id_cond       (id_cond),
    .sr_we         (sr_we),
    .sr_flags      (sr_flags),
    .exe_hold      (exe_hold),
    .id_stall      (id_stall),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Negedge-clocked status register, as in the core.
  always @(negedge clk or posedge rst) begin
    if (rst)        r_status <= 4'b0000;
    else if (sr_we) r_status <= sr_flags;
  end
  assign flags_cur = r_status;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [3:0] merge_model(input logic [3:0] cur, input logic [3:0] mask,
                                             input logic [3:0] data);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mask[i] ? data[i] : cur[i];
    return r;
  endfunction

  // Per-cycle scoreboard: sr_we must be high exactly in queued cycles.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        check("sr_we_missed", 32'(sr_we), 32'd1);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
        check("sr_we", 32'(sr_we), 32'd1);
        check("sr_flags", 32'(sr_flags), 32'(exp_q[0].flags));
        void'(exp_q.pop_front());
      end else begin
        check("sr_we_quiet", 32'(sr_we), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void clear_inputs();
    alu_s = 1'b0; mul_start = 1'b0; mul_s = 1'b0; msr_we = 1'b0; id_cond_valid = 1'b0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic do_alu(input logic [3:0] f);
    @(negedge clk);
    clear_inputs();
    alu_s = 1'b1; alu_flags = f;
    exp_q.push_back('{cyc: edge_cnt + 1, flags: f});
    m_status = f;
  endtask

  task automatic do_msr(input logic [3:0] mask, input logic [3:0] data);
    logic [3:0] e;
    @(negedge clk);
    clear_inputs();
    msr_we = 1'b1; msr_mask = mask; msr_data = data;
    e = merge_model(m_status, mask, data);
    exp_q.push_back('{cyc: edge_cnt + 1, flags: e});
    m_status = e;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    alu_flags = 4'h0; mul_flags = 4'h0; msr_mask = 4'h0; msr_data = 4'h0; id_cond = 4'h0;
    m_status = 4'h0;
    id_cond_valid = 1'b1;
    #12;
    check("rst_sr_we", 32'(sr_we), 32'd0);
    check("rst_sr_flags", 32'(sr_flags), 32'd0);
    check("rst_exe_hold", 32'(exe_hold), 32'd0);
    check("rst_id_stall", 32'(id_stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // ALU write 1001, visible in the status register one cycle later.
    do_alu(4'b1001);
    idle(2);
    check("alu_status", 32'(flags_cur), 32'b1001);

    // MSR masked write on top of 0101.
    do_alu(4'b0101);
    do_msr(4'b1100, 4'b1011);
    idle(2);
    check("msr_status", 32'(flags_cur), 32'b1001);
    do_msr(4'b0000, 4'b0110);
    idle(2);
    check("msr_mask0_status", 32'(flags_cur), 32'b1001);

    // Non-flag-setting multiply never enters the wait state.
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b0;
    @(negedge clk);
    clear_inputs();
    check("mul_nos_hold", 32'(exe_hold), 32'd0);
    idle(1);

    // Flag-setting multiply with ID stall behaviour.
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b1; mul_flags = 4'b0100;
    exp_q.push_back('{cyc: edge_cnt + MUL_LAT + 1, flags: 4'b0100});
    m_status = 4'b0100;
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      @(negedge clk);
      clear_inputs();
      id_cond_valid = 1'b1; id_cond = 4'b0000;
      #1;
      check("mul_hold", 32'(exe_hold), 32'd1);
      check("mul_stall_cond", 32'(id_stall), 32'd1);
      id_cond = COND_AL;
      #1;
      check("mul_stall_al", 32'(id_stall), 32'd0);
    end
    @(negedge clk);
    clear_inputs();
    id_cond_valid = 1'b1; id_cond = 4'b0000;
    #1;
    check("mul_done_hold", 32'(exe_hold), 32'd0);
    check("mul_done_stall", 32'(id_stall), 32'd0);
    check("mul_err", 32'(err), 32'd0);
    idle(2);

    // ALU held during a multiply is ignored, then re-presented afterwards.
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b1; mul_flags = 4'b1010;
    exp_q.push_back('{cyc: edge_cnt + MUL_LAT + 1, flags: 4'b1010});
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      @(negedge clk);
      clear_inputs();
      alu_s = 1'b1; alu_flags = 4'b0011;
    end
    m_status = 4'b1010;
    do_alu(4'b0011);
    idle(2);
    check("held_alu_err", 32'(err), 32'd0);

    // MSR and ALU together: MSR wins, err becomes sticky.
    @(negedge clk);
    clear_inputs();
    msr_we = 1'b1; msr_mask = 4'b0101; msr_data = 4'b1111;
    alu_s = 1'b1; alu_flags = 4'b1000;
    exp_q.push_back('{cyc: edge_cnt + 1, flags: merge_model(m_status, 4'b0101, 4'b1111)});
    m_status = merge_model(m_status, 4'b0101, 4'b1111);
    @(negedge clk);
    clear_inputs();
    check("collide_err", 32'(err), 32'd1);
    idle(3);
    check("collide_err_sticky", 32'(err), 32'd1);

    // Reset at cycle 1 of a multiply discards the pending write.
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b1; mul_flags = 4'b1111;
    idle(2);
    rst = 1'b1;
    #1;
    check("rst_mid_hold", 32'(exe_hold), 32'd0);
    check("rst_mid_flags", 32'(sr_flags), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_status = 4'b0000;
    idle(MUL_LAT + 2);
    check("rst_mid_status", 32'(flags_cur), 32'd0);
    check("rst_mid_err_after", 32'(err), 32'd0);

    // mul_start during the wait sets err and does not restart the count.
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b1; mul_flags = 4'b0110;
    exp_q.push_back('{cyc: edge_cnt + MUL_LAT + 1, flags: 4'b0110});
    m_status = 4'b0110;
    @(negedge clk);
    clear_inputs();
    mul_start = 1'b1; mul_s = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("restart_err", 32'(err), 32'd1);
    idle(MUL_LAT + 1);
    check("restart_hold", 32'(exe_hold), 32'd0);

    // Random back-to-back ALU / MSR traffic.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1, 0) == 1) do_alu(4'($urandom_range(15, 0)));
      else do_msr(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      if ($urandom_range(1, 0) == 1) idle(1);
    end
    idle(3);
    check("final_status", 32'(flags_cur), 32'(m_status));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
